// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider among N_REQ requesters, with id tags riding alongside.
// Optional DIV_ZERO_GUARD_EN: zero denominators bypass the divider and return all-ones / zero.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 8,
  parameter int DELAY   = 5,
  parameter int ID_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH_A-1:0]   req_num,
  input  logic [N_REQ*WIDTH_B-1:0]   req_den,
  output logic                       div_start,
  output logic [WIDTH_A-1:0]         div_numerator,
  output logic [WIDTH_B-1:0]         div_denominator,
  input  logic                       div_done,
  input  logic [WIDTH_A-1:0]         div_quotient,
  input  logic [WIDTH_B-1:0]         div_remainder,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WIDTH_A-1:0]         rsp_quotient,
  output logic [WIDTH_B-1:0]         rsp_remainder,
  output logic                       err_sticky
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_found;
  logic               accept;
  logic [WIDTH_A-1:0] sel_num;
  logic [WIDTH_B-1:0] sel_den;
  logic [ID_W-1:0]    issue_id;

  logic [DELAY-1:0]   tag_vld;
  logic [ID_W-1:0]    tag_id [DELAY];
  logic               fin_vld;
  logic [ID_W-1:0]    fin_id;
  logic               fire;
  logic               mismatch;

`ifdef DIV_ZERO_GUARD_EN
  logic               issue_zero;
  logic [DELAY-1:0]   tag_zero;
  logic               fin_zero;
`endif

  // First valid index at or above rr_ptr wins; if none, wrap to the lowest valid index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    if (!grant_found) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_num   = '0;
    sel_den   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_found && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_num      = req_num[i*WIDTH_A +: WIDTH_A];
        sel_den      = req_den[i*WIDTH_B +: WIDTH_B];
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (grant_idx == ID_W'(N_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_start       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      issue_id        <= '0;
`ifdef DIV_ZERO_GUARD_EN
      issue_zero      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        issue_id <= grant_idx;
      end
`ifdef DIV_ZERO_GUARD_EN
      // A zero denominator never reaches the divider; the tag alone carries it through.
      div_start  <= accept && (sel_den != '0);
      issue_zero <= accept && (sel_den == '0);
      if (accept && (sel_den != '0)) begin
        div_numerator   <= sel_num;
        div_denominator <= sel_den;
      end
`else
      div_start <= accept;
      if (accept) begin
        div_numerator   <= sel_num;
        div_denominator <= sel_den;
      end
`endif
    end
  end

  // Stage 0 samples alongside the divider's start, so the last stage lines up with div_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int s = 0; s < DELAY; s++) begin
        tag_id[s] <= '0;
      end
`ifdef DIV_ZERO_GUARD_EN
      tag_zero <= '0;
`endif
    end else begin
`ifdef DIV_ZERO_GUARD_EN
      tag_vld[0]  <= div_start | issue_zero;
      tag_zero[0] <= issue_zero;
`else
      tag_vld[0]  <= div_start;
`endif
      tag_id[0] <= issue_id;
      for (int s = 1; s < DELAY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
`ifdef DIV_ZERO_GUARD_EN
        tag_zero[s] <= tag_zero[s-1];
`endif
      end
    end
  end

  assign fin_vld = tag_vld[DELAY-1];
  assign fin_id  = tag_id[DELAY-1];

`ifdef DIV_ZERO_GUARD_EN
  assign fin_zero = tag_zero[DELAY-1];
  assign fire     = fin_vld && (fin_zero ? !div_done : div_done);
  assign mismatch = fin_zero ? div_done : (div_done != fin_vld);
`else
  assign fire     = fin_vld && div_done;
  assign mismatch = (div_done != fin_vld);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      err_sticky    <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid[i] <= fire && (fin_id == ID_W'(i));
      end
      if (fire) begin
`ifdef DIV_ZERO_GUARD_EN
        rsp_quotient  <= fin_zero ? {WIDTH_A{1'b1}} : div_quotient;
        rsp_remainder <= fin_zero ? '0 : div_remainder;
`else
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
`endif
      end
      if (mismatch) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 5-stage divider model behind it.
module tb_div_arbiter;

  localparam int N_REQ = 4;
  localparam int WA    = 16;
  localparam int WB    = 8;
  localparam int DELAY = 5;
  localparam int ID_W  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*WA-1:0] req_num;
  logic [N_REQ*WB-1:0] req_den;
  logic                div_start;
  logic [WA-1:0]       div_numerator;
  logic [WB-1:0]       div_denominator;
  logic                div_done;
  logic [WA-1:0]       div_quotient;
  logic [WB-1:0]       div_remainder;
  logic [N_REQ-1:0]    rsp_valid;
  logic [WA-1:0]       rsp_quotient;
  logic [WB-1:0]       rsp_remainder;
  logic                err_sticky;
  logic                force_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_arbiter #(.N_REQ(N_REQ), .WIDTH_A(WA), .WIDTH_B(WB), .DELAY(DELAY), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den),
    .div_start(div_start), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .err_sticky(err_sticky)
  );

  // Divider model: start sampled at edge E, done/result visible from edge E+DELAY-1.
  logic [DELAY-1:0] m_vld;
  logic [WA-1:0]    m_q [DELAY];
  logic [WB-1:0]    m_r [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int s = 0; s < DELAY; s++) begin
        m_q[s] <= '0;
        m_r[s] <= '0;
      end
    end else begin
      m_vld[0] <= div_start;
      m_q[0]   <= (div_denominator == 0) ? 16'hFFFF : div_numerator / WA'(div_denominator);
      m_r[0]   <= (div_denominator == 0) ? 8'h00 : WB'(div_numerator % WA'(div_denominator));
      for (int s = 1; s < DELAY; s++) begin
        m_vld[s] <= m_vld[s-1];
        m_q[s]   <= m_q[s-1];
        m_r[s]   <= m_r[s-1];
      end
    end
  end

  assign div_done      = m_vld[DELAY-1] | force_done;
  assign div_quotient  = m_q[DELAY-1];
  assign div_remainder = m_r[DELAY-1];

  task automatic set_req(input int i, input logic [WA-1:0] n, input logic [WB-1:0] d);
    req_num[i*WA +: WA] = n;
    req_den[i*WB +: WB] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '0;
    force_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [WA+WB+N_REQ+WA+WB+N_REQ+1:0] outs;
    rst_n      = 1'b0;
    req_valid  = '0;
    force_done = 1'b0;
    req_num    = '0;
    req_den    = '0;
    repeat (2) @(negedge clk);
    outs = {div_start, div_numerator, div_denominator, rsp_valid, rsp_quotient,
            rsp_remainder, err_sticky, req_ready};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_in: outputs %h expected 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    outs = {div_start, div_numerator, div_denominator, rsp_valid, rsp_quotient,
            rsp_remainder, err_sticky, req_ready};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_out: outputs %h expected 0", outs);
    end
    set_req(0, 16'd100, 8'd3);
    set_req(1, 16'd200, 8'd4);
    set_req(2, 16'd300, 8'd5);
    req_valid = 4'b0111;
    repeat (3) @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 4'b0000) begin
        n_err++;
        $display("[TB] FAIL reset_flush rsp_valid: got %b expected 0000 (cycle %0d)", rsp_valid, k);
      end
    end
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_flush err_sticky: got %b expected 0", err_sticky);
    end
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] exp_v;
    @(negedge clk);
    set_req(2, 16'd1000, 8'd7);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL single req_ready: got %b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if (div_start !== 1'b1 || div_numerator !== 16'd1000 || div_denominator !== 8'd7) begin
      n_err++;
      $display("[TB] FAIL single issue: start=%b num=%0d den=%0d expected 1/1000/7",
               div_start, div_numerator, div_denominator);
    end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      exp_v = (k == 7) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (rsp_valid !== exp_v) begin
        n_err++;
        $display("[TB] FAIL single rsp_valid T+%0d: got %b expected %b", k, rsp_valid, exp_v);
      end
      if (k == 7) begin
        n_cmp++;
        if (rsp_quotient !== 16'd142 || rsp_remainder !== 8'd6) begin
          n_err++;
          $display("[TB] FAIL single result: q=%0d r=%0d expected q=142 r=6",
                   rsp_quotient, rsp_remainder);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [WA-1:0]    exp_q [N_REQ];
    logic [WB-1:0]    exp_r [N_REQ];
    logic [N_REQ-1:0] exp_v;
    int               id;
    exp_q[0] = 16'd66;  exp_r[0] = 8'd2;
    exp_q[1] = 16'd100; exp_r[1] = 8'd0;
    exp_q[2] = 16'd15;  exp_r[2] = 8'd15;
    exp_q[3] = 16'd257; exp_r[3] = 8'd0;
    do_reset();
    set_req(0, 16'd200,   8'd3);
    set_req(1, 16'd1000,  8'd10);
    set_req(2, 16'd255,   8'd16);
    set_req(3, 16'd65535, 8'd255);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j >= 7 && j < 15) begin
        id    = (j - 7) % 4;
        exp_v = 4'b0001 << id;
        n_cmp++;
        if (rsp_valid !== exp_v || rsp_quotient !== exp_q[id] || rsp_remainder !== exp_r[id]) begin
          n_err++;
          $display("[TB] FAIL rr rsp %0d: valid=%b q=%0d r=%0d expected valid=%b q=%0d r=%0d",
                   j - 7, rsp_valid, rsp_quotient, rsp_remainder, exp_v, exp_q[id], exp_r[id]);
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin
          n_err++;
          $display("[TB] FAIL rr idle rsp_valid cycle %0d: got %b expected 0000", j, rsp_valid);
        end
      end
      if (j < 8) begin
        req_valid = 4'b1111;
        #1;
        exp_v = 4'b0001 << (j % 4);
        n_cmp++;
        if (req_ready !== exp_v) begin
          n_err++;
          $display("[TB] FAIL rr grant %0d: got %b expected %b", j, req_ready, exp_v);
        end
      end else begin
        req_valid = '0;
      end
    end
  endtask

  task automatic test_wrap();
    logic [N_REQ-1:0] exp_g [3];
    logic [N_REQ-1:0] exp_rsp [4];
    logic [N_REQ-1:0] exp_v;
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    exp_rsp[0] = 4'b0100; exp_rsp[1] = 4'b1000; exp_rsp[2] = 4'b0010; exp_rsp[3] = 4'b1000;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      exp_v = (j >= 7 && j <= 10) ? exp_rsp[j-7] : 4'b0000;
      n_cmp++;
      if (rsp_valid !== exp_v) begin
        n_err++;
        $display("[TB] FAIL wrap rsp_valid cycle %0d: got %b expected %b", j, rsp_valid, exp_v);
      end
      if (j == 0) begin
        req_valid = 4'b0100;
      end else if (j <= 3) begin
        req_valid = 4'b1010;
        #1;
        n_cmp++;
        if (req_ready !== exp_g[j-1]) begin
          n_err++;
          $display("[TB] FAIL wrap grant %0d: got %b expected %b", j - 1, req_ready, exp_g[j-1]);
        end
      end else begin
        req_valid = '0;
      end
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    n_cmp++;
    if (err_sticky !== 1'b1 || rsp_valid !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL mismatch set: err=%b rsp_valid=%b expected err=1 rsp_valid=0000",
               err_sticky, rsp_valid);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_sticky !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mismatch sticky: got %b expected 1", err_sticky);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mismatch clear: got %b expected 0", err_sticky);
    end
  endtask

`ifdef DIV_ZERO_GUARD_EN
  task automatic test_div_zero();
    logic [N_REQ-1:0] exp_v;
    do_reset();
    set_req(0, 16'd500, 8'd0);
    set_req(1, 16'd50,  8'd5);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 1) begin
        n_cmp++;
        if (div_start !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL zero no_start: got %b expected 0", div_start);
        end
      end
      if (j == 2) begin
        n_cmp++;
        if (div_start !== 1'b1 || div_numerator !== 16'd50 || div_denominator !== 8'd5) begin
          n_err++;
          $display("[TB] FAIL zero neighbour issue: start=%b num=%0d den=%0d expected 1/50/5",
                   div_start, div_numerator, div_denominator);
        end
      end
      exp_v = (j == 7) ? 4'b0001 : (j == 8) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (rsp_valid !== exp_v) begin
        n_err++;
        $display("[TB] FAIL zero rsp_valid cycle %0d: got %b expected %b", j, rsp_valid, exp_v);
      end
      if (j == 7) begin
        n_cmp++;
        if (rsp_quotient !== 16'hFFFF || rsp_remainder !== 8'd0) begin
          n_err++;
          $display("[TB] FAIL zero result: q=%h r=%h expected q=ffff r=00", rsp_quotient, rsp_remainder);
        end
      end
      if (j == 8) begin
        n_cmp++;
        if (rsp_quotient !== 16'd10 || rsp_remainder !== 8'd0) begin
          n_err++;
          $display("[TB] FAIL zero neighbour result: q=%0d r=%0d expected q=10 r=0",
                   rsp_quotient, rsp_remainder);
        end
      end
      if (j == 0) begin
        req_valid = 4'b0011;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
          n_err++;
          $display("[TB] FAIL zero grant0: got %b expected 0001", req_ready);
        end
      end else if (j == 1) begin
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
          n_err++;
          $display("[TB] FAIL zero grant1: got %b expected 0010", req_ready);
        end
      end else begin
        req_valid = '0;
      end
    end
    n_cmp++;
    if (err_sticky !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL zero err_sticky: got %b expected 0", err_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_mismatch();
`ifdef DIV_ZERO_GUARD_EN
    test_div_zero();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
